// File: rtl/pll_ctrl_pkg.sv
// Purpose : shared types and constants for the PLL reset/lock supervisor.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: state encoding (3-bit), retry counter width, constant max helper.
package pll_ctrl_pkg;

    localparam int RETRY_W = 8;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // Used to size the shared cycle counter from the largest cycle parameter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose : single-bit two-flop synchronizer, synchronous reset to 0.
// Latency : 2 i_clk cycles from i_d to o_q.
// Backpressure: none.
// Ports   : i_clk, i_rst (sync, active-high), i_d (async input), o_q (synchronized).
// Only compiled when PLL_RESET_SEQ_LOCK_SYNC_EN is defined; it has no user otherwise.
`ifdef PLL_RESET_SEQ_LOCK_SYNC_EN
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule
`endif

// File: rtl/pll_reset_seq.sv
// Purpose : PLL reset/lock supervisor: reset pulse, lock wait with timeout, stability
//           filter, bounded retries, sticky failure.
// Latency : all outputs registered; they reflect the state being entered.
// Backpressure: none; i_restart is a one-cycle request honoured immediately.
// Ports   : i_clk, i_rst (sync, active-high), i_locked (PLL lock), i_restart;
//           o_pll_rst, o_ready, o_fail (sticky), o_lock_lost (pulse), o_retries[7:0].
// Option  : PLL_RESET_SEQ_LOCK_SYNC_EN inserts a 2-flop synchronizer on i_locked
//           (2 cycles of lag); without it i_locked must already be i_clk-synchronous.
module pll_reset_seq
    import pll_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES        = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_locked,
    input  logic       i_restart,
    output logic       o_pll_rst,
    output logic       o_ready,
    output logic       o_fail,
    output logic       o_lock_lost,
    output logic [7:0] o_retries
);

    localparam int CNT_W = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES)) + 1;

    // Transitions fire on the last cycle of a phase so the new state is
    // visible exactly N cycles after entry.
    localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    logic lock_s;

`ifdef PLL_RESET_SEQ_LOCK_SYNC_EN
    sync_2ff u_lock_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_locked),
        .o_q   (lock_s)
    );
`else
    assign lock_s = i_locked;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retries_q, retries_d;
    logic               pll_rst_q, pll_rst_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;
    logic               lock_lost_q, lock_lost_d;

    always_comb begin
        state_d     = state_q;
        retries_d   = retries_q;
        lock_lost_d = 1'b0;

        if (i_restart) begin
            state_d   = ST_RESET;
            retries_d = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == RESET_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a timeout landing in the same cycle.
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retries_q == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            retries_d = retries_q + 1'b1;
                            state_d   = ST_RESET;
                        end
                    end
                end
                ST_STABLE: begin
                    // A dropout here is a glitch, not a failed attempt: no retry used.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Loss after a good lock starts a fresh sequence.
                    if (!lock_s) begin
                        state_d     = ST_RESET;
                        retries_d   = '0;
                        lock_lost_d = 1'b1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end

        // Counter restarts on every entry, including RESET re-entered by i_restart.
        if (i_restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q == ST_RUN) || (state_q == ST_FAIL)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        pll_rst_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            retries_q   <= '0;
            pll_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retries_q   <= retries_d;
            pll_rst_q   <= pll_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign o_pll_rst   = pll_rst_q;
    assign o_ready     = ready_q;
    assign o_fail      = fail_q;
    assign o_lock_lost = lock_lost_q;
    assign o_retries   = retries_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Purpose : self-checking bench for pll_reset_seq: directed scenarios plus random
//           lock/restart/reset stimulus against a behavioural reference model.
// Latency : model predicts registered outputs one edge after inputs are sampled.
// Backpressure: n/a.
module tb_pll_reset_seq;

    localparam int R  = 4;
    localparam int T  = 20;
    localparam int S  = 8;
    localparam int MR = 2;
`ifdef PLL_RESET_SEQ_LOCK_SYNC_EN
    localparam int SYNC_D = 2;
`else
    localparam int SYNC_D = 0;
`endif
    localparam logic [11:0] RST_VEC = 12'h800;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_locked = 1'b0;
    logic       i_restart = 1'b0;
    logic       o_pll_rst, o_ready, o_fail, o_lock_lost;
    logic [7:0] o_retries;

    pll_reset_seq #(
        .RESET_CYCLES        (R),
        .LOCK_TIMEOUT_CYCLES (T),
        .STABLE_CYCLES       (S),
        .MAX_RETRIES         (MR)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_locked    (i_locked),
        .i_restart   (i_restart),
        .o_pll_rst   (o_pll_rst),
        .o_ready     (o_ready),
        .o_fail      (o_fail),
        .o_lock_lost (o_lock_lost),
        .o_retries   (o_retries)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase name + time spent in phase, lock seen through a delay line.
    localparam int PH_RESET = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAIL = 4;
    int  m_phase = PH_RESET;
    int  m_age = 0;
    int  m_retries = 0;
    bit  m_lost = 0;
    bit  lk_q[$];

    function automatic logic [11:0] model_vec();
        logic prst, rdy, fl;
        prst = (m_phase == PH_RESET) || (m_phase == PH_FAIL);
        rdy  = (m_phase == PH_RUN);
        fl   = (m_phase == PH_FAIL);
        return {prst, rdy, fl, m_lost, 8'(m_retries)};
    endfunction

    task automatic model_step();
        bit ls;
        int nxt;
        if (i_rst) begin
            m_phase = PH_RESET; m_age = 0; m_retries = 0; m_lost = 0;
            lk_q.delete();
            for (int k = 0; k < SYNC_D; k++) lk_q.push_back(1'b0);
            return;
        end
        if (SYNC_D == 0) begin
            ls = i_locked;
        end else begin
            ls = lk_q.pop_front();
            lk_q.push_back(i_locked);
        end
        nxt = m_phase;
        m_lost = 0;
        if (i_restart) begin
            nxt = PH_RESET;
            m_retries = 0;
        end else if (m_phase == PH_RESET) begin
            if (m_age + 1 >= R) nxt = PH_WAIT;
        end else if (m_phase == PH_WAIT) begin
            if (ls) nxt = PH_STABLE;
            else if (m_age + 1 >= T) begin
                if (m_retries >= MR) nxt = PH_FAIL;
                else begin m_retries++; nxt = PH_RESET; end
            end
        end else if (m_phase == PH_STABLE) begin
            if (!ls) nxt = PH_WAIT;
            else if (m_age + 1 >= S) nxt = PH_RUN;
        end else if (m_phase == PH_RUN) begin
            if (!ls) begin nxt = PH_RESET; m_lost = 1; m_retries = 0; end
        end
        if (i_restart || nxt != m_phase) m_age = 0;
        else m_age++;
        m_phase = nxt;
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        chk("outs", {20'd0, o_pll_rst, o_ready, o_fail, o_lock_lost, o_retries},
                    {20'd0, model_vec()});
    endtask

    function automatic logic obs(input int sel);
        case (sel)
            0: return o_pll_rst;
            1: return o_ready;
            2: return o_fail;
            default: return o_lock_lost;
        endcase
    endfunction

    // Ticks until the selected output equals val; n = -1 if the budget expires.
    task automatic ticks_until(input int sel, input logic val, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (obs(sel) === val) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic pulse_rst();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        int n;
        int run_left;
        int exp_n;

        // Reset values
        repeat (3) tick();
        chk("rst_vals", {20'd0, o_pll_rst, o_ready, o_fail, o_lock_lost, o_retries}, {20'd0, RST_VEC});

        // Nominal lock
        i_rst = 1'b0;
        ticks_until(0, 1'b0, 50, n);
        chk("rst_len", n, R);
        repeat (9) tick();
        i_locked = 1'b1;
        ticks_until(1, 1'b1, 100, n);
        chk("lock2rdy", n, SYNC_D + 1 + S);
        chk("nom_retries", o_retries, 0);

        // Loss in RUN
        repeat (5) tick();
        i_locked = 1'b0;
        ticks_until(3, 1'b1, 10, n);
        chk("lost_lat", n, SYNC_D + 1);
        chk("lost_rdy", o_ready, 0);
        chk("lost_prst", o_pll_rst, 1);
        tick();
        chk("lost_pulse", o_lock_lost, 0);
        i_locked = 1'b1;
        exp_n = ((R > 1 + SYNC_D) ? R : 1 + SYNC_D) + S;
        ticks_until(1, 1'b1, 100, n);
        chk("relock_rdy", n, exp_n);

        // Glitch during STABLE
        i_locked = 1'b0;
        pulse_rst();
        ticks_until(0, 1'b0, 50, n);
        i_locked = 1'b1;
        repeat (5) tick();
        i_locked = 1'b0;
        tick();
        i_locked = 1'b1;
        ticks_until(1, 1'b1, 100, n);
        chk("glitch_rdy", n, SYNC_D + 1 + S);
        chk("glitch_retries", o_retries, 0);

        // Never locks
        i_locked = 1'b0;
        pulse_rst();
        ticks_until(2, 1'b1, 400, n);
        chk("fail_time", n, (MR + 1) * (R + T));
        chk("fail_retries", o_retries, MR);
        chk("fail_prst", o_pll_rst, 1);
        repeat (10) tick();
        chk("fail_sticky", o_fail, 1);

        // Restart from FAIL
        i_locked = 1'b1;
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        chk("rs_fail", o_fail, 0);
        chk("rs_retries", o_retries, 0);
        chk("rs_prst", o_pll_rst, 1);
        ticks_until(0, 1'b0, 50, n);
        chk("rs_rst_len", n, R);
        ticks_until(1, 1'b1, 100, n);
        chk("rs_rdy", n, S + 1);

        // Restart coinciding with timeout expiry
        i_locked = 1'b0;
        pulse_rst();
        repeat (R + T - 1) tick();
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        chk("prio_rs", {20'd0, o_pll_rst, o_ready, o_fail, o_lock_lost, o_retries}, {20'd0, RST_VEC});
        ticks_until(0, 1'b0, 50, n);
        chk("prio_rs_len", n, R);

        // i_rst together with i_restart, from a state with a retry consumed
        repeat (T) tick();
        chk("pre_prio_retries", o_retries, 1);
        i_rst = 1'b1;
        i_restart = 1'b1;
        tick();
        i_rst = 1'b0;
        i_restart = 1'b0;
        chk("prio_rst", {20'd0, o_pll_rst, o_ready, o_fail, o_lock_lost, o_retries}, {20'd0, RST_VEC});
        ticks_until(0, 1'b0, 50, n);
        chk("prio_rst_len", n, R);

        // Random lock behaviour with occasional restart/reset
        run_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0) begin
                i_locked = ~i_locked;
                run_left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6)
                                                        : $urandom_range(8, 90);
            end
            run_left--;
            i_restart = ($urandom_range(0, 299) == 0);
            i_rst     = ($urandom_range(0, 799) == 0);
            tick();
        end
        i_restart = 1'b0;
        i_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
